// File: rtl/wash_sequencer_if.sv
// Bundle of control inputs and status outputs of the wash-cycle sequencer.
//   en          : stage enable (low forces IDLE)
//   mode        : 0 quick, 1 standard, 2 heavy, 3 spin-only (sampled at start)
//   start_pause : one-cycle start / pause / resume pulse
//   phase       : 0 IDLE .. 6 DONE (saved phase while paused)
//   rem_sec     : remaining ticks in the current phase
//   st_light    : one-hot phase lights, bit6 paused, bit7 running
//   wt_light    : water level, thermometer code
//   running     : a phase timer is advancing
//   paused      : sequencer is in PAUSE
//   done        : sequencer is in DONE
//   overtime    : seconds spent in DONE, saturating
//   state_dbg   : raw FSM state, for debug/checkers
// Handshake: there is no valid/ready pair; start_pause is a single-cycle
// event sampled on every rising clock edge, and all status outputs are
// registered and valid every cycle.
interface wash_sequencer_if;
  logic       en;
  logic [1:0] mode;
  logic       start_pause;
  logic [2:0] phase;
  logic [7:0] rem_sec;
  logic [7:0] st_light;
  logic [7:0] wt_light;
  logic       running;
  logic       paused;
  logic       done;
  logic [7:0] overtime;
  logic [2:0] state_dbg;

  modport master (
    output en, mode, start_pause,
    input  phase, rem_sec, st_light, wt_light, running, paused, done,
           overtime, state_dbg
  );

  modport slave (
    input  en, mode, start_pause,
    output phase, rem_sec, st_light, wt_light, running, paused, done,
           overtime, state_dbg
  );
endinterface

// File: rtl/wash_sequencer.sv
// Timed wash-cycle controller. Steps FILL, WASH, DRAIN, RINSE, SPIN on a
// one-second tick, supports pause/resume, then counts overtime in DONE.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : wash_sequencer_if.slave (controls in, registered status out)
module wash_sequencer #(
  parameter int TICK_DIV = 100000000,
  parameter int OT_MAX   = 255
) (
  input logic            clk,
  input logic            rst,
  wash_sequencer_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    OT_SAT    = 8'(OT_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6,
    S_PAUSE = 3'd7
  } state_t;

  function automatic logic [3:0] fill_target(input logic [1:0] m);
    case (m)
      2'd0:    return 4'd4;
      2'd1:    return 4'd6;
      2'd2:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  // Ticks spent in phase s. DRAIN lasts as long as the current water level.
  function automatic logic [3:0] phase_dur(input state_t s, input logic [1:0] m,
                                           input logic [3:0] lvl);
    case (s)
      S_FILL:  return fill_target(m);
      S_WASH:  case (m) 2'd0: return 4'd5; 2'd1: return 4'd8;
                        2'd2: return 4'd12; default: return 4'd0; endcase
      S_DRAIN: return lvl;
      S_RINSE: case (m) 2'd0: return 4'd3; 2'd1: return 4'd4;
                        2'd2: return 4'd6; default: return 4'd0; endcase
      S_SPIN:  case (m) 2'd0: return 4'd4; 2'd1: return 4'd4;
                        default: return 4'd6; endcase
      default: return 4'd0;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      S_FILL:  return S_WASH;
      S_WASH:  return S_DRAIN;
      S_DRAIN: return S_RINSE;
      S_RINSE: return S_SPIN;
      default: return S_DONE;
    endcase
  endfunction

  // First phase at or after s whose duration is non-zero (DONE if none).
  function automatic state_t first_live(input state_t s, input logic [1:0] m,
                                        input logic [3:0] lvl);
    state_t c;
    c = s;
    for (int k = 0; k < 5; k++) begin
      if (c != S_DONE && phase_dur(c, m, lvl) == 4'd0) c = succ(c);
    end
    return c;
  endfunction

  state_t        state_q, state_d, saved_q, saved_d, nxt;
  logic [7:0]    rem_q, rem_d;
  logic [3:0]    level_q, level_d;
  logic [PW-1:0] presc_q, presc_d, presc_inc;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    ot_q, ot_d;
  logic          tick;

  // Registered status outputs, computed from the next-state values.
  state_t     disp;
  logic       running_d, paused_d, done_d;
  logic [7:0] st_d, wt_d;
  logic [8:0] thermo;
  logic [2:0] phase_q;
  logic [7:0] st_q, wt_q;
  logic       running_q, paused_q, done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      saved_q <= S_IDLE;
      rem_q   <= '0;
      level_q <= '0;
      presc_q <= '0;
      mode_q  <= '0;
      ot_q    <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      rem_q   <= rem_d;
      level_q <= level_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      ot_q    <= ot_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    rem_d     = rem_q;
    level_d   = level_q;
    presc_d   = presc_q;
    mode_d    = mode_q;
    ot_d      = ot_q;
    nxt       = S_DONE;
    tick      = (presc_q == TICK_LAST);
    presc_inc = tick ? '0 : presc_q + PW'(1);

    if (!bus.en) begin
      state_d = S_IDLE;
      saved_d = S_IDLE;
      rem_d   = '0;
      level_d = '0;
      presc_d = '0;
      mode_d  = '0;
      ot_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_pause) begin
            mode_d  = bus.mode;
            nxt     = first_live(S_FILL, bus.mode, 4'd0);
            state_d = nxt;
            rem_d   = {4'd0, phase_dur(nxt, bus.mode, 4'd0)};
            presc_d = '0;
          end
        end
        S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN: begin
          if (bus.start_pause) begin
            // Pause beats a coincident tick: nothing advances this cycle.
            saved_d = state_q;
            state_d = S_PAUSE;
          end else begin
            presc_d = presc_inc;
            if (tick) begin
              rem_d = rem_q - 8'd1;
              if (state_q == S_FILL)  level_d = level_q + 4'd1;
              if (state_q == S_DRAIN) level_d = level_q - 4'd1;
              if (rem_q == 8'd1) begin
                nxt     = first_live(succ(state_q), mode_q, level_d);
                state_d = nxt;
                rem_d   = {4'd0, phase_dur(nxt, mode_q, level_d)};
              end
            end
          end
        end
        S_DONE: begin
          presc_d = presc_inc;
          if (tick && ot_q < OT_SAT) ot_d = ot_q + 8'd1;
        end
        S_PAUSE: begin
          if (bus.start_pause) state_d = saved_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    disp      = (state_d == S_PAUSE) ? saved_d : state_d;
    paused_d  = (state_d == S_PAUSE);
    done_d    = (state_d == S_DONE);
    running_d = (state_d == S_FILL) || (state_d == S_WASH) || (state_d == S_DRAIN) ||
                (state_d == S_RINSE) || (state_d == S_SPIN);
    st_d      = 8'h00;
    case (disp)
      S_FILL:  st_d = 8'h01;
      S_WASH:  st_d = 8'h02;
      S_DRAIN: st_d = 8'h04;
      S_RINSE: st_d = 8'h08;
      S_SPIN:  st_d = 8'h10;
      S_DONE:  st_d = 8'h20;
      default: st_d = 8'h00;
    endcase
    st_d[6] = paused_d;
    st_d[7] = running_d;
    thermo  = (9'd1 << level_d) - 9'd1;
    wt_d    = thermo[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= '0;
      st_q      <= '0;
      wt_q      <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= disp;
      st_q      <= st_d;
      wt_q      <= wt_d;
      running_q <= running_d;
      paused_q  <= paused_d;
      done_q    <= done_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.rem_sec   = rem_q;
  assign bus.st_light  = st_q;
  assign bus.wt_light  = wt_q;
  assign bus.running   = running_q;
  assign bus.paused    = paused_q;
  assign bus.done      = done_q;
  assign bus.overtime  = ot_q;
  assign bus.state_dbg = state_q;

endmodule
